psum_deskew_collector: RTL and testbench
========================================

Name: psum_deskew_collector

Overview:
- Sits below the last PE row of the systolic array and drains the partial sums that flow out of its bottom edge.
- Column j's result for a given input vector leaves the array j cycles after column 0's. The block delays each column so all ARRAYWIDTH sums of one vector line up into a single word.
- Aligned words are buffered in a FIFO and handed downstream over a valid/ready handshake.
- An almost_full credit signal lets the activation feeder stop issuing vectors before the FIFO can overflow.

Parameters:
- DATASIZE, default `DATASIZE (8): activation/weight width; each psum is 2*DATASIZE bits.
- ARRAYWIDTH, default `ARRAYWIDTH (4): number of array columns; must be >= 2.
- FIFO_DEPTH, default 8: number of aligned-vector entries; power of two, must be >= ARRAYWIDTH+1.

Ports:
- clk  in  1  clock; all state is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_psum  in  2*DATASIZE*ARRAYWIDTH  bottom-edge psum bus from the array; column j occupies bits [2*(j+1)*DATASIZE-1 : 2*j*DATASIZE].
- in_valid  in  1  column 0 holds a finished psum this cycle.
- out_psum  out  2*DATASIZE*ARRAYWIDTH  aligned vector at the FIFO head; same column packing as in_psum.
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  downstream accepts out_psum this cycle.
- almost_full  out  1  free entries <= ARRAYWIDTH; the feeder must stop issuing new vectors while this is high.
- overflow  out  1  sticky; an aligned word was dropped.
- vec_count  out  16  aligned vectors popped since reset; wraps at 2^16.

Behaviour:
- Reset:
  - Reset asserts while rst=0, with no clock required.
  - All delay registers, the valid pipe, FIFO pointers, occupancy, overflow and vec_count are cleared to 0.
  - Resulting outputs: out_valid=0, almost_full=0, out_psum=0.
  - A reset mid-operation discards in-flight and buffered data. No partial vector is emitted after release.
- Deskew:
  - Column j goes through a delay chain of ARRAYWIDTH-1-j registers, so column ARRAYWIDTH-1 is undelayed.
  - in_valid goes through a register chain of ARRAYWIDTH-1 stages.
  - The valid chain output is the push strobe for the aligned word.
  - Delay registers shift every cycle and ignore valid; the array cannot stall.
- Latency:
  - in_valid=1 at cycle t means columns 0..W-1 present their sums at cycles t..t+W-1.
  - The aligned word is written at the edge ending cycle t+W-1.
  - If the FIFO was empty, out_valid=1 from cycle t+W. There is no combinational bypass.
- FIFO:
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle are both performed and occupancy is unchanged.
  - When full, a push is accepted only if a pop happens in the same cycle.
  - A push while full with no pop drops the word and sets overflow=1 until reset. FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked in log2(FIFO_DEPTH)+1 bits.
  - A pop while empty is impossible because out_valid=0 blocks it.
- Handshake:
  - out_psum is the FIFO head. It is stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop.
- almost_full is registered and computed from the next-state occupancy.
  - Threshold: FIFO_DEPTH - occupancy <= ARRAYWIDTH.
  - This covers up to ARRAYWIDTH-1 vectors still in the deskew pipe, plus one cycle of feeder reaction.
- vec_count increments on every pop and wraps 0xFFFF -> 0.
- Arithmetic: none. Psums pass through bit-exact with no sign handling.

Decomposition:
- Shared include: DATASIZE/ARRAYWIDTH come from vsrc/config.v.
- Add a `PSUMWIDTH macro (2*`DATASIZE) there so the array and this block agree on the packed width.
- One natural sub-module: sync_fifo, parameterized width/depth, exposing push, pop, full, empty and count.
- The deskew delay chains are generated inline with a genvar loop over columns.

Test Plan:
All cases use W=4, DATASIZE=8, FIFO_DEPTH=8.
- Single vector: in_valid=1 at cycle 0; column j driven to 0x0100*(j+1) at cycle j, garbage at other cycles. Required: out_valid rises at cycle 4, out_psum=0x0400_0300_0200_0100, held until out_ready=1, then out_valid=0 and vec_count=1.
- Back-to-back: 6 consecutive vectors with out_ready=1. Required: 6 aligned words in order on consecutive cycles 4..9, no overflow, vec_count=6.
- Backpressure: out_ready=0 and 8 vectors streamed. Required: almost_full rises once occupancy reaches 4, FIFO holds 8 entries, overflow=0. A 9th vector gives overflow=1 and entry 9 is lost. Draining returns exactly entries 1-8.
- Full with simultaneous pop: FIFO full, out_ready=1 and a push in the same cycle. Required: push accepted, occupancy stays 8, overflow stays 0.
- Reset mid-stream: rst=0 asynchronously between clock edges with 3 words buffered and 2 in flight. Required: out_valid, almost_full, overflow and vec_count are all 0 immediately. After release, nothing is emitted without new in_valid.
- Counter wrap: force 65536 pops. Required: vec_count returns to 0.

Source files
------------

// File: rtl/psum_deskew_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_deskew_collector_pkg
//  Description : Shared constants and helpers for the partial-sum deskew
//                collector that drains the bottom edge of the systolic array.
//                DATASIZE / ARRAYWIDTH defaults live here, so the array and
//                the collector agree on the packed psum width.
//  Revision    : 1.0 - initial release
// ============================================================================
package psum_deskew_collector_pkg;

    // Array geometry defaults shared with the PE array.
    localparam int c_DATASIZE     = 8;
    localparam int c_ARRAYWIDTH   = 4;
    // One psum is a full-precision product: twice the operand width.
    localparam int c_PSUMWIDTH    = 2 * c_DATASIZE;
    localparam int c_FIFO_DEPTH   = 8;
    localparam int c_VEC_COUNT_W  = 16;

    // Width of a bus carrying one psum per array column.
    function automatic int psum_bus_width(input int datasize, input int arraywidth);
        return 2 * datasize * arraywidth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_deskew_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : psum_deskew_collector_if
//  Description : Bundle between the array bottom edge, the collector and the
//                downstream consumer.
//                  in_psum / in_valid        : skewed psums from the array
//                  out_psum/out_valid/ready  : aligned-vector handshake
//                  almost_full               : credit back to the feeder
//                  overflow / vec_count      : status
//                modport slave  - the collector
//                modport master - the surrounding logic / environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface psum_deskew_collector_if
    import psum_deskew_collector_pkg::*;
#(
    parameter int DATASIZE   = c_DATASIZE,
    parameter int ARRAYWIDTH = c_ARRAYWIDTH
);
    localparam int c_BUS_W = psum_bus_width(DATASIZE, ARRAYWIDTH);

    logic [c_BUS_W-1:0]       in_psum;
    logic                     in_valid;
    logic [c_BUS_W-1:0]       out_psum;
    logic                     out_valid;
    logic                     out_ready;
    logic                     almost_full;
    logic                     overflow;
    logic [c_VEC_COUNT_W-1:0] vec_count;

    modport slave (
        input  in_psum,
        input  in_valid,
        input  out_ready,
        output out_psum,
        output out_valid,
        output almost_full,
        output overflow,
        output vec_count
    );

    modport master (
        output in_psum,
        output in_valid,
        output out_ready,
        input  out_psum,
        input  out_valid,
        input  almost_full,
        input  overflow,
        input  vec_count
    );

endinterface
`default_nettype wire

// File: rtl/psum_deskew_collector_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO for aligned psum vectors.
//                  clk, rst  : clock, asynchronous active-low reset
//                  push/din  : write request and data
//                  pop       : read request (ignored when empty)
//                  dout      : head entry (zero while empty)
//                  full/empty/count : occupancy status
//                When full, a push is taken only together with a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic      [CNT_W-1:0] count
);
    localparam int               c_PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign full      = (r_count == c_FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_pop_ok  = pop && !empty;
    // A full FIFO frees its head slot in the same cycle it pops.
    assign w_push_ok = push && (!full || w_pop_ok);

    // Storage is not reset; the head is masked while empty instead, so
    // nothing stale is ever visible on dout.
    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_deskew_collector.sv
`default_nettype none
// ============================================================================
//  Module      : psum_deskew_collector
//  Description : Drains the bottom edge of the systolic array. Column j's
//                psum for a vector arrives j cycles after column 0's; each
//                column is delayed by ARRAYWIDTH-1-j cycles so one vector
//                lines up into a single word, which is buffered in a FIFO
//                and offered downstream over valid/ready.
//                  clk, rst    : clock, asynchronous active-low reset
//                  bus (slave) : in_psum/in_valid from the array,
//                                out_psum/out_valid/out_ready downstream,
//                                almost_full credit, sticky overflow,
//                                16-bit popped-vector counter
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_deskew_collector
    import psum_deskew_collector_pkg::*;
#(
    parameter int DATASIZE   = c_DATASIZE,
    parameter int ARRAYWIDTH = c_ARRAYWIDTH,   // >= 2
    parameter int FIFO_DEPTH = c_FIFO_DEPTH    // power of two, >= ARRAYWIDTH+1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    psum_deskew_collector_if.slave bus
);
    localparam int               c_PW        = 2 * DATASIZE;
    localparam int               c_BUS_W     = psum_bus_width(DATASIZE, ARRAYWIDTH);
    localparam int               c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_FREE   = c_CNT_W'(ARRAYWIDTH);

    logic [c_BUS_W-1:0]       w_aligned;
    logic [ARRAYWIDTH-2:0]    r_vld_pipe;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_drop;
    logic                     w_push_acc;
    logic [c_BUS_W-1:0]       w_fifo_dout;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [c_CNT_W-1:0]       w_fifo_count;
    logic [c_CNT_W-1:0]       w_occ_next;
    logic [c_CNT_W-1:0]       w_free_next;
    logic                     r_almost_full;
    logic                     r_overflow;
    logic [c_VEC_COUNT_W-1:0] r_vec_count;

    // ------------------------------------------------------------------
    // Deskew: the array never stalls, so the chains shift unconditionally.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < ARRAYWIDTH; j++) begin : g_col
        localparam int c_DLY = ARRAYWIDTH - 1 - j;
        if (c_DLY == 0) begin : g_pass
            assign w_aligned[j*c_PW +: c_PW] = bus.in_psum[j*c_PW +: c_PW];
        end else begin : g_dly
            logic [c_PW-1:0] r_dly [c_DLY];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < c_DLY; k++) begin
                        r_dly[k] <= '0;
                    end
                end else begin
                    r_dly[0] <= bus.in_psum[j*c_PW +: c_PW];
                    for (int k = 1; k < c_DLY; k++) begin
                        r_dly[k] <= r_dly[k-1];
                    end
                end
            end
            assign w_aligned[j*c_PW +: c_PW] = r_dly[c_DLY-1];
        end
    end

    // in_valid marks column 0; delaying it as long as column 0 gives the
    // strobe for the cycle in which the whole vector is aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= bus.in_valid;
            for (int k = 1; k < ARRAYWIDTH - 1; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
            end
        end
    end

    assign w_push = r_vld_pipe[ARRAYWIDTH-2];

    // ------------------------------------------------------------------
    // Buffer
    // ------------------------------------------------------------------
    assign w_pop      = !w_fifo_empty && bus.out_ready;
    assign w_drop     = w_push && w_fifo_full && !w_pop;
    assign w_push_acc = w_push && !w_drop;

    sync_fifo #(
        .WIDTH (c_BUS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_aligned),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Occupancy after this edge; almost_full is registered from it so the
    // flag is in step with the FIFO contents it describes.
    always_comb begin
        w_occ_next = w_fifo_count;
        if (w_push_acc && !w_pop) begin
            w_occ_next = w_fifo_count + c_CNT_W'(1);
        end else if (!w_push_acc && w_pop) begin
            w_occ_next = w_fifo_count - c_CNT_W'(1);
        end
    end

    // Headroom of ARRAYWIDTH covers ARRAYWIDTH-1 vectors still in the
    // deskew chains plus one cycle of feeder reaction.
    assign w_free_next = c_DEPTH_CNT - w_occ_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_vec_count   <= '0;
        end else begin
            r_almost_full <= (w_free_next <= c_AF_FREE);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_vec_count <= r_vec_count + c_VEC_COUNT_W'(1);
            end
        end
    end

    assign bus.out_psum    = w_fifo_dout;
    assign bus.out_valid   = !w_fifo_empty;
    assign bus.almost_full = r_almost_full;
    assign bus.overflow    = r_overflow;
    assign bus.vec_count   = r_vec_count;

endmodule
`default_nettype wire

// File: tb/tb_psum_deskew_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_deskew_collector
//  Description : Self-checking bench for psum_deskew_collector (W=4,
//                DATASIZE=8, FIFO_DEPTH=8). A queue-based reference model
//                tracks each issued vector, collects column j from the bus
//                j cycles after issue, and moves completed vectors through
//                an ideal bounded FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_deskew_collector;
    import psum_deskew_collector_pkg::*;

    localparam int W     = 4;
    localparam int DS    = 8;
    localparam int PW    = 2 * DS;
    localparam int BW    = PW * W;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_deskew_collector_if #(.DATASIZE(DS), .ARRAYWIDTH(W)) bus ();

    psum_deskew_collector #(
        .DATASIZE   (DS),
        .ARRAYWIDTH (W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc      = 0;
    int            obs_pops = 0;
    int            base;
    int            iss_q[$];
    logic [BW-1:0] part_q[$];
    logic [BW-1:0] mq[$];
    bit            m_ovf;
    bit            m_af;
    logic [15:0]   m_vc;
    bit            directed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("out_psum", bus.out_psum, mq[0]);
        chk("almost_full", 64'(bus.almost_full), 64'(m_af));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("vec_count", 64'(bus.vec_count), 64'(m_vc));
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic tick(input bit v, input bit rdy);
        logic [BW-1:0] d;
        logic [BW-1:0] w;
        int            age;
        check_outputs();
        d = {$urandom, $urandom};
        if (v) begin
            iss_q.push_back(cyc);
            part_q.push_back('0);
        end
        for (int i = 0; i < iss_q.size(); i++) begin
            age = cyc - iss_q[i];
            if (directed) d[age*PW +: PW] = PW'((age + 1) * 256);
            w = part_q[i];
            w[age*PW +: PW] = d[age*PW +: PW];
            part_q[i] = w;
        end
        bus.in_valid  = v;
        bus.out_ready = rdy;
        bus.in_psum   = d;
        if (bus.out_valid === 1'b1 && rdy) obs_pops++;
        // Edge: pop first, so a full FIFO can take a push in the same edge.
        if (mq.size() != 0 && rdy) begin
            void'(mq.pop_front());
            m_vc = m_vc + 16'd1;
        end
        if (iss_q.size() != 0 && (cyc - iss_q[0]) == W - 1) begin
            w = part_q.pop_front();
            void'(iss_q.pop_front());
            if (mq.size() < DEPTH) mq.push_back(w);
            else m_ovf = 1'b1;
        end
        m_af = (DEPTH - mq.size()) <= W;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_almost_full", 64'(bus.almost_full), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_vec_count", 64'(bus.vec_count), 64'd0);
        chk("rst_out_psum", bus.out_psum, 64'd0);
        iss_q.delete();
        part_q.delete();
        mq.delete();
        m_ovf = 1'b0;
        m_af  = 1'b0;
        m_vc  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_psum   = '0;
        directed      = 1'b0;
        #1;
        do_reset();

        // Single vector with directed column values
        directed = 1'b1;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        chk("t1_valid_c3", 64'(bus.out_valid), 64'd0);
        tick(0, 0);
        chk("t1_valid_c4", 64'(bus.out_valid), 64'd1);
        chk("t1_psum", bus.out_psum, 64'h0400_0300_0200_0100);
        tick(0, 0);
        tick(0, 0);
        chk("t1_hold", bus.out_psum, 64'h0400_0300_0200_0100);
        tick(0, 1);
        chk("t1_popped", 64'(bus.out_valid), 64'd0);
        chk("t1_vec_count", 64'(bus.vec_count), 64'd1);
        directed = 1'b0;

        // Back-to-back vectors, consumer always ready
        base = obs_pops;
        for (int k = 0; k < 6; k++) tick(1, 1);
        for (int k = 0; k < 6; k++) tick(0, 1);
        chk("t2_pops", 64'(obs_pops - base), 64'd6);
        chk("t2_vec_count", 64'(bus.vec_count), 64'd7);
        chk("t2_overflow", 64'(bus.overflow), 64'd0);

        // Backpressure: fill, overflow with a 9th vector, then drain
        for (int k = 0; k < 11; k++) begin
            tick(k < 8, 0);
            if (k == 5) chk("t3_af_occ3", 64'(bus.almost_full), 64'd0);
            if (k == 6) chk("t3_af_occ4", 64'(bus.almost_full), 64'd1);
        end
        chk("t3_full_no_ovf", 64'(bus.overflow), 64'd0);
        tick(1, 0);
        for (int k = 0; k < 3; k++) tick(0, 0);
        chk("t3_overflow", 64'(bus.overflow), 64'd1);
        base = obs_pops;
        for (int k = 0; k < 10; k++) tick(0, 1);
        chk("t3_drained", 64'(obs_pops - base), 64'd8);

        // Full FIFO with a push and pop on the same edge
        do_reset();
        for (int k = 0; k < 11; k++) tick(k < 8, 0);
        chk("t4_af_full", 64'(bus.almost_full), 64'd1);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 1);
        chk("t4_overflow", 64'(bus.overflow), 64'd0);
        chk("t4_valid", 64'(bus.out_valid), 64'd1);
        base = obs_pops;
        for (int k = 0; k < 10; k++) tick(0, 1);
        chk("t4_drained", 64'(obs_pops - base), 64'd8);

        // Reset with three buffered and two in flight
        for (int k = 0; k < 5; k++) tick(1, 0);
        tick(0, 0);
        chk("t5_pre_valid", 64'(bus.out_valid), 64'd1);
        do_reset();
        for (int k = 0; k < 10; k++) tick(0, 0);
        chk("t5_quiet", 64'(bus.out_valid), 64'd0);

        // vec_count wrap after 65536 pops
        base = obs_pops;
        for (int k = 0; k < 65536; k++) tick(1, 1);
        for (int k = 0; k < 6; k++) tick(0, 1);
        chk("t6_pops", 64'(obs_pops - base), 64'd65536);
        chk("t6_wrap", 64'(bus.vec_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
